// File: rtl/mls_learn_table_if.sv
// mls_learn_table_if: learn-request and mactable-command bus of the SMAC learning table.
//   Learn side : iv_smac, iv_inport, i_learn_wr (to table), o_learn_ready (from table)
//   Mactable   : ov_smac_inport, ov_entry_addr, o_mactable_wr, o_entry_del (from table)
//   master     : parser/mactable side (drives learn requests, receives commands)
//   slave      : the learning table
interface mls_learn_table_if #(
    parameter int unsigned PORT_W = 9,
    parameter int unsigned ADDR_W = 5
);
    logic [47:0]          iv_smac;
    logic [PORT_W-1:0]    iv_inport;
    logic                 i_learn_wr;
    logic                 o_learn_ready;
    logic [48+PORT_W-1:0] ov_smac_inport;
    logic [ADDR_W-1:0]    ov_entry_addr;
    logic                 o_mactable_wr;
    logic                 o_entry_del;

    modport master (
        output iv_smac, iv_inport, i_learn_wr,
        input  o_learn_ready, ov_smac_inport, ov_entry_addr, o_mactable_wr, o_entry_del
    );

    modport slave (
        input  iv_smac, iv_inport, i_learn_wr,
        output o_learn_ready, ov_smac_inport, ov_entry_addr, o_mactable_wr, o_entry_del
    );
endinterface

// File: rtl/mls_learn_table.sv
// mls_learn_table: DEPTH-entry parallel-compare SMAC learning table with aging.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   bus (slave)       learn requests in, mactable write/delete commands out
//   i_age_tick        aging period pulse
//   ov_drop_cnt       saturating count of dropped learn requests
//   ov_valid_cnt      number of valid entries
// Optional build macro: MLS_MCAST_FILTER_EN discards group-bit SMAC requests in IDLE.
module mls_learn_table #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned PORT_W  = 9,
    parameter int unsigned AGE_W   = 4,
    parameter int unsigned AGE_MAX = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mls_learn_table_if.slave     bus,
    input  logic                 i_age_tick,
    output logic [15:0]          ov_drop_cnt,
    output logic [ADDR_W:0]      ov_valid_cnt
);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned DATA_W = 48 + PORT_W;

    typedef enum logic [1:0] {ST_IDLE, ST_COMPARE, ST_UPDATE, ST_AGE_SCAN} state_t;
    typedef enum logic [1:0] {OP_REFRESH, OP_MOVE, OP_FILL, OP_DROP} op_t;

    state_t              r_state, w_state_nxt;
    op_t                 r_op, w_op_nxt;
    logic [ADDR_W-1:0]   r_op_idx, w_op_idx_nxt;

    logic [47:0]         r_smac [DEPTH];
    logic [PORT_W-1:0]   r_port [DEPTH];
    logic [AGE_W-1:0]    r_age  [DEPTH];
    logic [DEPTH-1:0]    r_valid;

    logic [47:0]         r_req_smac;
    logic [PORT_W-1:0]   r_req_port;
    logic                r_age_pend;
    logic [ADDR_W-1:0]   r_scan_idx;

    logic                r_mt_wr, r_mt_del, r_ready;
    logic [ADDR_W-1:0]   r_mt_addr;
    logic [DATA_W-1:0]   r_mt_data;
    logic [15:0]         r_drop_cnt;
    logic [CNT_W-1:0]    r_valid_cnt;

    logic                w_wr_nxt, w_del_nxt, w_accept, w_start_scan, w_mcast;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_hit, w_free;
    logic [ADDR_W-1:0]   w_hit_idx, w_free_idx;
    logic [1:0]          w_drop_inc;
    logic [16:0]         w_drop_sum;

`ifdef MLS_MCAST_FILTER_EN
    assign w_mcast = bus.iv_smac[40];
`else
    assign w_mcast = 1'b0;
`endif

    assign bus.o_learn_ready  = r_ready;
    assign bus.o_mactable_wr  = r_mt_wr;
    assign bus.o_entry_del    = r_mt_del;
    assign bus.ov_entry_addr  = r_mt_addr;
    assign bus.ov_smac_inport = r_mt_data;
    assign ov_drop_cnt        = r_drop_cnt;
    assign ov_valid_cnt       = r_valid_cnt;

    // Parallel compare; descending loop leaves the lowest matching/free index.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_smac[i] == r_req_smac)) begin
                w_hit     = 1'b1;
                w_hit_idx = ADDR_W'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = ADDR_W'(i);
            end
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_op_idx_nxt = r_op_idx;
        w_accept     = 1'b0;
        w_start_scan = 1'b0;
        w_wr_nxt     = 1'b0;
        w_del_nxt    = 1'b0;
        w_addr_nxt   = r_mt_addr;
        w_data_nxt   = r_mt_data;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_learn_wr) begin
                    if (!w_mcast) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_COMPARE;
                    end
                end else if (r_age_pend) begin
                    w_start_scan = 1'b1;
                    w_state_nxt  = ST_AGE_SCAN;
                end
            end
            ST_COMPARE: begin
                // Decision and mactable command are registered here so the write lands in UPDATE.
                w_state_nxt = ST_UPDATE;
                if (w_hit) begin
                    w_op_idx_nxt = w_hit_idx;
                    if (r_port[w_hit_idx] == r_req_port) begin
                        w_op_nxt = OP_REFRESH;
                    end else begin
                        w_op_nxt   = OP_MOVE;
                        w_wr_nxt   = 1'b1;
                        w_addr_nxt = w_hit_idx;
                        w_data_nxt = {r_req_port, r_req_smac};
                    end
                end else if (w_free) begin
                    w_op_nxt     = OP_FILL;
                    w_op_idx_nxt = w_free_idx;
                    w_wr_nxt     = 1'b1;
                    w_addr_nxt   = w_free_idx;
                    w_data_nxt   = {r_req_port, r_req_smac};
                end else begin
                    w_op_nxt = OP_DROP;
                end
            end
            ST_UPDATE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_AGE_SCAN: begin
                if (r_valid[r_scan_idx] && (r_age[r_scan_idx] == AGE_W'(AGE_MAX))) begin
                    w_wr_nxt   = 1'b1;
                    w_del_nxt  = 1'b1;
                    w_addr_nxt = r_scan_idx;
                    w_data_nxt = '0;
                end
                if (r_scan_idx == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Drops: request while busy, filtered group SMAC, or table full.
    always_comb begin
        w_drop_inc = 2'(bus.i_learn_wr && !r_ready)
                   + 2'(bus.i_learn_wr && r_ready && w_mcast)
                   + 2'((r_state == ST_UPDATE) && (r_op == OP_DROP));
        w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_inc);
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Table, aging and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_age[i] <= '0;
            end
            r_age_pend  <= 1'b0;
            r_scan_idx  <= '0;
            r_op        <= OP_REFRESH;
            r_op_idx    <= '0;
            r_req_smac  <= '0;
            r_req_port  <= '0;
            r_mt_wr     <= 1'b0;
            r_mt_del    <= 1'b0;
            r_mt_addr   <= '0;
            r_mt_data   <= '0;
            r_ready     <= 1'b1;
            r_drop_cnt  <= '0;
            r_valid_cnt <= '0;
        end else begin
            r_mt_wr   <= w_wr_nxt;
            r_mt_del  <= w_del_nxt;
            r_mt_addr <= w_addr_nxt;
            r_mt_data <= w_data_nxt;
            r_ready   <= (w_state_nxt == ST_IDLE);
            r_op      <= w_op_nxt;
            r_op_idx  <= w_op_idx_nxt;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

            // A tick wins over the clear so a tick during a scan re-arms it.
            if (i_age_tick) begin
                r_age_pend <= 1'b1;
            end else if (w_start_scan) begin
                r_age_pend <= 1'b0;
            end

            if (w_accept) begin
                r_req_smac <= bus.iv_smac;
                r_req_port <= bus.iv_inport;
            end

            if (w_start_scan) begin
                r_scan_idx <= '0;
            end else if (r_state == ST_AGE_SCAN) begin
                r_scan_idx <= r_scan_idx + ADDR_W'(1);
            end

            if (r_state == ST_UPDATE) begin
                case (r_op)
                    OP_REFRESH: r_age[r_op_idx] <= '0;
                    OP_MOVE: begin
                        r_port[r_op_idx] <= r_req_port;
                        r_age[r_op_idx]  <= '0;
                    end
                    OP_FILL: begin
                        r_valid[r_op_idx] <= 1'b1;
                        r_smac[r_op_idx]  <= r_req_smac;
                        r_port[r_op_idx]  <= r_req_port;
                        r_age[r_op_idx]   <= '0;
                        r_valid_cnt       <= r_valid_cnt + CNT_W'(1);
                    end
                    default: ;
                endcase
            end

            if ((r_state == ST_AGE_SCAN) && r_valid[r_scan_idx]) begin
                if (r_age[r_scan_idx] == AGE_W'(AGE_MAX)) begin
                    r_valid[r_scan_idx] <= 1'b0;
                    r_valid_cnt         <= r_valid_cnt - CNT_W'(1);
                end else begin
                    r_age[r_scan_idx] <= r_age[r_scan_idx] + AGE_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mls_learn_table.sv
// tb_mls_learn_table: directed bench for mls_learn_table with a write/delete scoreboard.
module tb_mls_learn_table;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned PORT_W = 9;

    typedef struct packed {
        logic                 del;
        logic [ADDR_W-1:0]    addr;
        logic [48+PORT_W-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            age_tick;
    logic [15:0]     drop_cnt;
    logic [ADDR_W:0] valid_cnt;

    int   checks = 0;
    int   errors = 0;
    int   exp_drop = 0;
    exp_t q[$];

    localparam logic [47:0] M0 = 48'h001122334455;
    localparam logic [47:0] M2 = 48'h0A0000000002;
    localparam logic [47:0] M3 = 48'h0A0000000003;
    localparam logic [47:0] M4 = 48'h0A0000000004;
    localparam logic [47:0] MC = 48'h01005E000001;

    always #5 clk = ~clk;

    mls_learn_table_if #(.PORT_W(PORT_W), .ADDR_W(ADDR_W)) bus ();

    mls_learn_table dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus),
        .i_age_tick   (age_tick),
        .ov_drop_cnt  (drop_cnt),
        .ov_valid_cnt (valid_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic del, input logic [ADDR_W-1:0] addr, input logic [48+PORT_W-1:0] data);
        exp_t e;
        e.del  = del;
        e.addr = addr;
        e.data = data;
        q.push_back(e);
    endtask

    // One learn request from IDLE; returns in the next IDLE cycle.
    task automatic learn(input logic [47:0] mac, input logic [PORT_W-1:0] port,
                         input bit exp_wr, input logic [ADDR_W-1:0] exp_addr);
        if (exp_wr) push_exp(1'b0, exp_addr, {port, mac});
        @(negedge clk);
        bus.iv_smac    = mac;
        bus.iv_inport  = port;
        bus.i_learn_wr = 1'b1;
        @(negedge clk);
        bus.i_learn_wr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One tick and wait for the whole scan to finish.
    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            age_tick = 1'b1;
            @(negedge clk);
            age_tick = 1'b0;
            repeat (36) @(negedge clk);
        end
    endtask

    // Monitor: every mactable write must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.o_mactable_wr) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: del=%0b addr=%0d data=0x%0h, none expected",
                         bus.o_entry_del, bus.ov_entry_addr, bus.ov_smac_inport);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({bus.o_entry_del, bus.ov_entry_addr, bus.ov_smac_inport} !== e) begin
                    errors++;
                    $display("FAIL write: got del=%0b addr=%0d data=0x%0h expected del=%0b addr=%0d data=0x%0h",
                             bus.o_entry_del, bus.ov_entry_addr, bus.ov_smac_inport, e.del, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        age_tick       = 1'b0;
        bus.iv_smac    = '0;
        bus.iv_inport  = '0;
        bus.i_learn_wr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready", 64'(bus.o_learn_ready), 64'd1);
        chk("rst_wr", 64'(bus.o_mactable_wr), 64'd0);
        chk("rst_del", 64'(bus.o_entry_del), 64'd0);
        chk("rst_addr", 64'(bus.ov_entry_addr), 64'd0);
        chk("rst_data", 64'(bus.ov_smac_inport), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_valid", 64'(valid_cnt), 64'd0);

        // First learn with latency checks: write at T+2, ready again at T+3
        push_exp(1'b0, 5'd0, {9'h004, M0});
        @(negedge clk);
        bus.iv_smac = M0; bus.iv_inport = 9'h004; bus.i_learn_wr = 1'b1;
        @(negedge clk);
        bus.i_learn_wr = 1'b0;
        chk("lat_t1_wr", 64'(bus.o_mactable_wr), 64'd0);
        chk("lat_t1_ready", 64'(bus.o_learn_ready), 64'd0);
        @(negedge clk);
        chk("lat_t2_wr", 64'(bus.o_mactable_wr), 64'd1);
        @(negedge clk);
        chk("lat_t3_ready", 64'(bus.o_learn_ready), 64'd1);
        chk("valid_after_first", 64'(valid_cnt), 64'd1);

        // Refresh (no write), then port move
        learn(M0, 9'h004, 1'b0, 5'd0);
        learn(M0, 9'h010, 1'b1, 5'd0);
        chk("valid_after_move", 64'(valid_cnt), 64'd1);

        // Fill the table, overflow, hit on a full table
        for (int i = 1; i < 32; i++) learn(48'h020000000000 | 48'(i), 9'h001, 1'b1, 5'(i));
        chk("valid_full", 64'(valid_cnt), 64'd32);
        learn(48'h030000000000, 9'h001, 1'b0, 5'd0);
        exp_drop++;
        chk("drop_full", 64'(drop_cnt), 64'(exp_drop));
        learn(M0, 9'h010, 1'b0, 5'd0);
        learn(M0, 9'h020, 1'b1, 5'd0);
        chk("valid_full_move", 64'(valid_cnt), 64'd32);
        chk("drop_full_move", 64'(drop_cnt), 64'(exp_drop));

        // Reset between scenarios
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_drop = 0;
        chk("rst2_valid", 64'(valid_cnt), 64'd0);
        chk("rst2_drop", 64'(drop_cnt), 64'd0);

        // Aging: survive 15 scans, deleted on the 16th
        learn(M0, 9'h004, 1'b1, 5'd0);
        ticks(15);
        chk("age15_valid", 64'(valid_cnt), 64'd1);
        push_exp(1'b1, 5'd0, '0);
        ticks(1);
        chk("age16_valid", 64'(valid_cnt), 64'd0);

        // Aging with a refresh after tick 10
        learn(M0, 9'h004, 1'b1, 5'd0);
        ticks(10);
        learn(M0, 9'h004, 1'b0, 5'd0);
        ticks(6);
        chk("refresh_age16_valid", 64'(valid_cnt), 64'd1);
        push_exp(1'b1, 5'd0, '0);
        ticks(10);
        chk("refresh_age26_valid", 64'(valid_cnt), 64'd0);

        // Learn request during AGE_SCAN is dropped
        learn(M0, 9'h004, 1'b1, 5'd0);
        @(negedge clk); age_tick = 1'b1;
        @(negedge clk); age_tick = 1'b0;
        repeat (5) @(negedge clk);
        bus.iv_smac = 48'h0B0000000001; bus.iv_inport = 9'h002; bus.i_learn_wr = 1'b1;
        @(negedge clk);
        bus.i_learn_wr = 1'b0;
        exp_drop++;
        repeat (35) @(negedge clk);
        chk("scan_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        chk("scan_drop_valid", 64'(valid_cnt), 64'd1);

        // Learn request during COMPARE is dropped; M3 must remain unknown
        push_exp(1'b0, 5'd1, {9'h008, M2});
        @(negedge clk);
        bus.iv_smac = M2; bus.iv_inport = 9'h008; bus.i_learn_wr = 1'b1;
        @(negedge clk);
        bus.iv_smac = M3;
        @(negedge clk);
        bus.i_learn_wr = 1'b0;
        exp_drop++;
        repeat (2) @(negedge clk);
        chk("cmp_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        learn(M3, 9'h008, 1'b1, 5'd2);
        chk("cmp_drop_valid", 64'(valid_cnt), 64'd3);

        // Learn and tick together: learn served first, scan follows
        push_exp(1'b0, 5'd3, {9'h040, M4});
        @(negedge clk);
        bus.iv_smac = M4; bus.iv_inport = 9'h040; bus.i_learn_wr = 1'b1; age_tick = 1'b1;
        @(negedge clk);
        bus.i_learn_wr = 1'b0; age_tick = 1'b0;
        repeat (2) @(negedge clk);
        chk("learn_tick_idle_ready", 64'(bus.o_learn_ready), 64'd1);
        @(negedge clk);
        chk("learn_tick_scan_busy", 64'(bus.o_learn_ready), 64'd0);
        repeat (36) @(negedge clk);
        chk("learn_tick_valid", 64'(valid_cnt), 64'd4);
        chk("learn_tick_drop", 64'(drop_cnt), 64'(exp_drop));

        // Group-bit SMAC
`ifdef MLS_MCAST_FILTER_EN
        learn(MC, 9'h002, 1'b0, 5'd0);
        exp_drop++;
        chk("mcast_valid", 64'(valid_cnt), 64'd4);
`else
        learn(MC, 9'h002, 1'b1, 5'd4);
        chk("mcast_valid", 64'(valid_cnt), 64'd5);
`endif
        chk("mcast_drop", 64'(drop_cnt), 64'(exp_drop));

        // Reset in the middle of a scan
        @(negedge clk); age_tick = 1'b1;
        @(negedge clk); age_tick = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 64'(bus.o_learn_ready), 64'd1);
        chk("midrst_wr", 64'(bus.o_mactable_wr), 64'd0);
        chk("midrst_del", 64'(bus.o_entry_del), 64'd0);
        chk("midrst_addr", 64'(bus.ov_entry_addr), 64'd0);
        chk("midrst_data", 64'(bus.ov_smac_inport), 64'd0);
        chk("midrst_drop", 64'(drop_cnt), 64'd0);
        chk("midrst_valid", 64'(valid_cnt), 64'd0);
        repeat (40) @(negedge clk);
        chk("midrst_idle_ready", 64'(bus.o_learn_ready), 64'd1);

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
